// File: rtl/contador_pkg.sv
// Shared constants and helpers for the multi-digit BCD counter.
//   DIGIT_W          : bits per BCD digit
//   DIGIT_MAX        : largest legal BCD digit value
//   DEFAULT_DIGITS   : default number of digits
//   DEFAULT_PRESCALE : default clk cycles per count step (50 MHz -> 1 Hz)
package contador_pkg;

  localparam int unsigned DIGIT_W          = 4;
  localparam int unsigned DIGIT_MAX        = 9;
  localparam int unsigned DEFAULT_DIGITS   = 2;
  localparam int unsigned DEFAULT_PRESCALE = 50_000_000;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  // Saturate a loaded nibble to the largest legal BCD digit.
  function automatic bcd_digit_t clamp_digit(input bcd_digit_t d);
    return (d > DIGIT_W'(DIGIT_MAX)) ? DIGIT_W'(DIGIT_MAX) : d;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Clock-enable prescaler: counts 0..PRESCALE-1 while enabled and raises
// strobe combinationally on the last count of each period.
//   clk    : system clock
//   reset  : synchronous active-low reset
//   enable : 1 = count, 0 = hold
//   clear  : synchronous restart of the period (counter to 0)
//   strobe : (count == PRESCALE-1) && enable
module divisor_tick
  import contador_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic strobe
);

  localparam int unsigned    CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign strobe = enable && (cnt_q == LAST);

  // Next count: clear wins, wrap on the step, otherwise advance when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (strobe) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/contador_bcd_multi.sv
// Multi-digit up/down BCD counter advanced by a prescaled clock enable.
//   clk        : system clock (only clock in the block)
//   reset      : synchronous active-low reset
//   enable     : 1 = prescaler and counter run, 0 = freeze
//   up_down    : 1 = count up, 0 = count down (sampled at the step edge)
//   load       : synchronous load strobe, restarts the prescaler period
//   load_value : BCD value to load, digit 0 in [3:0]; nibbles > 9 clamp to 9
//   outcome    : current BCD count, digit 0 in [3:0]
//   tick       : registered one-cycle pulse with each new count
//   carry      : registered one-cycle pulse when the count wraps
module contador_bcd_multi
  import contador_pkg::*;
#(
  parameter int unsigned DIGITS   = DEFAULT_DIGITS,
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      up_down,
  input  logic                      load,
  input  logic [DIGITS*DIGIT_W-1:0] load_value,
  output logic [DIGITS*DIGIT_W-1:0] outcome,
  output logic                      tick,
  output logic                      carry
);

  localparam int unsigned W     = DIGITS * DIGIT_W;
  localparam bcd_digit_t  MAX_D = DIGIT_W'(DIGIT_MAX);

  logic              step_c;
  logic [DIGITS-1:0] at_limit_c;
  logic [W-1:0]      stepped_c;
  logic [W-1:0]      clamped_c;
  logic              wrap_c;

  logic [W-1:0] outcome_q, outcome_d;
  logic         tick_q, tick_d;
  logic         carry_q, carry_d;

  // The load also restarts the period so the next step is a full PRESCALE away.
  divisor_tick #(
    .PRESCALE(PRESCALE)
  ) u_divisor_tick (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .clear (load),
    .strobe(step_c)
  );

  // Per-digit step: a digit moves only when every lower digit sits at its
  // wrap point (9 going up, 0 going down), i.e. the carry/borrow reaches it.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_t cur_c;
    logic       cin_c;

    assign cur_c         = outcome_q[i*DIGIT_W +: DIGIT_W];
    assign at_limit_c[i] = up_down ? (cur_c == MAX_D) : (cur_c == '0);

    if (i == 0) begin : g_lsd
      assign cin_c = 1'b1;
    end else begin : g_upper
      assign cin_c = &at_limit_c[i-1:0];
    end

    assign stepped_c[i*DIGIT_W +: DIGIT_W] =
        !cin_c  ? cur_c :
        up_down ? ((cur_c == MAX_D) ? '0    : cur_c + DIGIT_W'(1)) :
                  ((cur_c == '0)    ? MAX_D : cur_c - DIGIT_W'(1));

    assign clamped_c[i*DIGIT_W +: DIGIT_W] = clamp_digit(load_value[i*DIGIT_W +: DIGIT_W]);
  end

  // All digits at their wrap point: the step rolls the whole count over.
  assign wrap_c = &at_limit_c;

  // Load beats step; tick/carry only accompany a real step.
  always_comb begin
    outcome_d = outcome_q;
    tick_d    = 1'b0;
    carry_d   = 1'b0;
    if (load) begin
      outcome_d = clamped_c;
    end else if (step_c) begin
      outcome_d = stepped_c;
      tick_d    = 1'b1;
      carry_d   = wrap_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      outcome_q <= '0;
      tick_q    <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      outcome_q <= outcome_d;
      tick_q    <= tick_d;
      carry_q   <= carry_d;
    end
  end

  assign outcome = outcome_q;
  assign tick    = tick_q;
  assign carry   = carry_q;

endmodule

// File: doc/contador_bcd_multi.md
CONTADOR_BCD_MULTI -- requirements
Module: contador_bcd_multi

Interface
REQ-001 Parameter DIGITS, default 2: number of BCD digits, legal range 1..8.
REQ-002 Parameter PRESCALE, default 50_000_000: clk cycles per count step (50 MHz -> 1 Hz), legal range >= 1.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on rising clk.
REQ-005 enable  input  1  1 = prescaler and counter run; 0 = both freeze.
REQ-006 up_down  input  1  1 = count up, 0 = count down.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_value  input  4*DIGITS  BCD value to load; digit 0 in bits [3:0].
REQ-009 outcome  output  4*DIGITS  current BCD count; digit 0 in bits [3:0].
REQ-010 tick  output  1  one-cycle pulse marking a count step.
REQ-011 carry  output  1  one-cycle pulse on wrap (up: all-9 -> 0; down: 0 -> all-9).

Function
REQ-012 The block SHALL use a clock-enable scheme only; no derived or gated clock SHALL drive any flop.
REQ-013 Prescaler SHALL count 0..PRESCALE-1 while enable=1 and hold its value while enable=0.
REQ-014 Internal step strobe SHALL be (prescaler == PRESCALE-1) AND enable; on that edge the prescaler returns to 0.
REQ-015 PRESCALE=1 SHALL produce a step on every enabled cycle.
REQ-016 On a step with up_down=1, outcome SHALL increment in BCD: a digit at 9 becomes 0 and carries into the next digit.
REQ-017 On a step with up_down=0, outcome SHALL decrement in BCD: a digit at 0 becomes 9 and borrows from the next digit.
REQ-018 Up from all-9s SHALL wrap to 0; down from 0 SHALL wrap to all-9s; carry SHALL pulse in both cases.
REQ-019 tick and carry SHALL be registered, high for exactly the one cycle following the step edge, coincident with the new outcome.
REQ-020 up_down SHALL be sampled at the step edge; a direction change takes effect on the next step with no extra step.
REQ-021 load=1 SHALL, on the same edge, copy load_value into outcome and clear the prescaler; tick and carry stay 0 that cycle.
REQ-022 Any load_value digit greater than 9 SHALL be clamped to 9 at load.
REQ-023 Priority SHALL be reset > load > step; load with enable=0 SHALL still load.
REQ-024 Every digit of outcome SHALL always be in 0..9.

Reset
REQ-025 reset=0 at a rising edge SHALL set outcome=0, prescaler=0, tick=0, carry=0, overriding load and enable.
REQ-026 Reset asserted mid-count SHALL discard the partial prescaler count; the first step after release SHALL occur PRESCALE enabled cycles later.

Structure
REQ-027 Shared package contador_pkg SHALL hold the BCD digit width constant (4), the digit maximum (9), and the default PRESCALE and DIGITS values.
REQ-028 Prescaler SHALL be a sub-module divisor_tick (params PRESCALE; ports clk, reset, enable, clear, strobe), width $clog2(PRESCALE) with a minimum of 1.
REQ-029 BCD digit chain SHALL be generated per digit in contador_bcd_multi, with ripple carry/borrow between digits.

Verification (DIGITS=2, PRESCALE=4 unless stated)
REQ-030 Reset low 2 cycles, then enable=1, up_down=1 -> first tick 4 cycles after release, outcome=0x01; after 99 steps, outcome=0x99.
REQ-031 From 0x99, one more up step -> outcome=0x00 with tick=1 and carry=1 in the same cycle.
REQ-032 up_down=0 from 0x00 -> outcome=0x99 with carry=1; next step -> 0x98, carry=0; from 0x10 one down step -> 0x09.
REQ-033 enable=0 for 10 cycles mid-period (prescaler=2) -> outcome, prescaler and tick frozen; on re-enable, next tick after 2 cycles.
REQ-034 load=1, load_value=0x5C, coincident with a step -> outcome=0x59, tick=0, carry=0; next step 4 cycles later -> 0x60.
REQ-035 PRESCALE=1, DIGITS=1, up: tick every cycle, sequence 0..9,0 with carry on the wrap; reset=0 asserted concurrently with load=1 -> outcome=0.
